messbauer_spectrum_accumulator: RTL and testbench

- Downstream consumer of the generator and differential-discriminator outputs.
- Tracks the current velocity channel from start/channel pulses and classifies each lower_threshold pulse as a valid gamma event or a rejected one; a pulse is rejected when upper_threshold is seen during it.
- Accumulates valid events into a per-channel saturating counter RAM (the Mossbauer spectrum), with an independent read port for host/readout logic.

---
 rtl/messbauer_spectrum_accumulator.sv | 243 ++++++++++++++++++++++++
 tb/tb_messbauer_spectrum_accumulator.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/messbauer_spectrum_accumulator.sv
// Mossbauer spectrum accumulator.
// Tracks the velocity channel from the generator's start/channel pulses,
// classifies discriminator pulses as valid or rejected gamma events, and
// counts valid events per channel in a saturating counter RAM. A second,
// independent port lets host logic read the spectrum.
//
// Read handshake: rd_en is a one-cycle request (no ready, never stalls);
// rd_valid is asserted exactly one cycle later with rd_data for that request,
// and is low in every other cycle.
module messbauer_spectrum_accumulator #(
    parameter int CHANNEL_NUMBER = 512,
    parameter int COUNTER_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     start,
    input  logic                     channel,
    input  logic                     lower_threshold,
    input  logic                     upper_threshold,
    input  logic                     clear,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic [ADDR_WIDTH-1:0]    current_channel,
    output logic [15:0]              frame_count,
    output logic                     sequence_error,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    // S_CLEAR is encoded as zero so every output reads 0 while in reset.
    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_ACQUIRE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(CHANNEL_NUMBER - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

    // Pulse pins packed as {upper, lower, channel, start}.
    logic [3:0] pin_meta;
    logic [3:0] pin_sync;
    logic [2:0] pin_prev;

    logic start_rise;
    logic chan_rise;
    logic lower_rise;
    logic lower_fall;
    logic lower_s;
    logic upper_s;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  sweeping;
    logic                  clearing;

    logic reject_flag;
    logic event_fire;

    logic                     p1_valid;
    logic [ADDR_WIDTH-1:0]    p1_addr;
    logic                     p2_valid;
    logic [ADDR_WIDTH-1:0]    p2_addr;
    logic [COUNTER_WIDTH-1:0] p2_ram;
    logic                     fwd_hit;
    logic [COUNTER_WIDTH-1:0] fwd_data;
    logic [COUNTER_WIDTH-1:0] p2_value;
    logic [COUNTER_WIDTH-1:0] p2_incr;

    logic                     wr_en;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [COUNTER_WIDTH-1:0] wr_data;

    logic [COUNTER_WIDTH-1:0] mem [CHANNEL_NUMBER];

    assign start_rise = pin_sync[0] & ~pin_prev[0];
    assign chan_rise  = pin_sync[1] & ~pin_prev[1];
    assign lower_rise = pin_sync[2] & ~pin_prev[2];
    assign lower_fall = ~pin_sync[2] & pin_prev[2];
    assign lower_s    = pin_sync[2];
    assign upper_s    = pin_sync[3];

    // The sweep only runs once 'sweeping' is set; the first cycle after reset
    // just arms it so that busy starts low out of reset.
    assign clearing  = (state == S_CLEAR) && sweeping;
    assign busy      = sweeping;
    assign fsm_state = state;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pin_meta <= '0;
            pin_sync <= '0;
            pin_prev <= '0;
        end else begin
            pin_meta <= {upper_threshold, lower_threshold, channel, start};
            pin_sync <= pin_meta;
            pin_prev <= pin_sync[2:0];
        end
    end

    // Reject flag: re-armed on lower rise, set whenever upper overlaps lower.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            reject_flag <= 1'b0;
        end else if (lower_rise) begin
            reject_flag <= upper_s;
        end else if (upper_s && lower_s) begin
            reject_flag <= 1'b1;
        end
    end

    // Upper seen during the fall-strobe cycle itself also rejects the pulse.
    assign event_fire = lower_fall && !reject_flag && !upper_s &&
                        (state == S_ACQUIRE) && !clear;

    // Control FSM: clear sweep, idle until first start, then channel tracking.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state           <= S_CLEAR;
            clr_addr        <= '0;
            sweeping        <= 1'b0;
            current_channel <= '0;
            frame_count     <= '0;
            sequence_error  <= 1'b0;
        end else if (clear) begin
            state           <= S_CLEAR;
            clr_addr        <= '0;
            sweeping        <= 1'b1;
            current_channel <= '0;
            frame_count     <= '0;
            sequence_error  <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    current_channel <= '0;
                    frame_count     <= '0;
                    sequence_error  <= 1'b0;
                    if (!sweeping) begin
                        sweeping <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ADDR_ONE;
                        if (clr_addr == LAST_ADDR) begin
                            state    <= S_IDLE;
                            sweeping <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (start_rise) begin
                        state           <= S_ACQUIRE;
                        current_channel <= '0;
                        frame_count     <= frame_count + 16'd1;
                    end
                end
                S_ACQUIRE: begin
                    if (start_rise) begin
                        current_channel <= '0;
                        if (frame_count != 16'hFFFF) begin
                            frame_count <= frame_count + 16'd1;
                        end
                    end else if (chan_rise) begin
                        if (current_channel == LAST_ADDR) begin
                            current_channel <= '0;
                            sequence_error  <= 1'b1;
                        end else begin
                            current_channel <= current_channel + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    // Saturating increment of the stage-2 value, forwarded if the previous
    // write landed on the same address while this one was being read.
    assign p2_value = fwd_hit ? fwd_data : p2_ram;
    assign p2_incr  = (p2_value == '1) ? p2_value : p2_value + CNT_ONE;

    // Update pipeline control: event -> RAM read -> write back; clear aborts.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            p1_valid <= 1'b0;
            p1_addr  <= '0;
            p2_valid <= 1'b0;
            p2_addr  <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (clear || (state == S_CLEAR)) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            fwd_hit  <= 1'b0;
        end else begin
            p1_valid <= event_fire;
            p1_addr  <= current_channel;
            p2_valid <= p1_valid;
            p2_addr  <= p1_addr;
            fwd_hit  <= p1_valid && p2_valid && (p2_addr == p1_addr);
            fwd_data <= p2_incr;
        end
    end

    // Port A write select: the clear sweep owns the port while it runs.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = p2_addr;
        wr_data = p2_incr;
        if (clearing) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (p2_valid && !clear) begin
            wr_en = 1'b1;
        end
    end

    // Counter RAM port A: write-back and pipeline read (read-before-write).
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        p2_ram <= mem[p1_addr];
    end

    // Counter RAM port B: host read, returns the pre-write value on collision.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_messbauer_spectrum_accumulator.sv
// Bench for messbauer_spectrum_accumulator: a full-size instance plus a small
// 8-channel, 4-bit instance that shares the stimulus and shows saturation.
module tb_messbauer_spectrum_accumulator;

    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_ACQUIRE = 2'd2;

    // Clock / reset
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    logic       start = 1'b0;
    logic       channel = 1'b0;
    logic       lower_threshold = 1'b0;
    logic       upper_threshold = 1'b0;
    logic       clear = 1'b0;
    logic       rd_en = 1'b0;
    logic [8:0] rd_addr = '0;

    logic [31:0] rd_data;
    logic        rd_valid;
    logic [8:0]  current_channel;
    logic [15:0] frame_count;
    logic        sequence_error;
    logic        busy;
    logic [1:0]  fsm_state;

    logic [3:0]  sat_rd_data;
    logic        sat_rd_valid;
    logic [2:0]  sat_current_channel;
    logic [15:0] sat_frame_count;
    logic        sat_sequence_error;
    logic        sat_busy;
    logic [1:0]  sat_fsm_state;

    messbauer_spectrum_accumulator dut (
        .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .current_channel(current_channel),
        .frame_count(frame_count), .sequence_error(sequence_error),
        .busy(busy), .fsm_state(fsm_state)
    );

    messbauer_spectrum_accumulator #(
        .CHANNEL_NUMBER(8), .COUNTER_WIDTH(4), .ADDR_WIDTH(3)
    ) dut_sat (
        .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .rd_data(sat_rd_data),
        .rd_valid(sat_rd_valid), .current_channel(sat_current_channel),
        .frame_count(sat_frame_count), .sequence_error(sat_sequence_error),
        .busy(sat_busy), .fsm_state(sat_fsm_state)
    );

    int checks = 0;
    int failures = 0;

    // Reference model of the spectrum and channel tracking
    logic [31:0] exp_cnt [512];
    logic [3:0]  exp_sat [8];
    int          cur_ch = 0;
    bit          acq = 0;
    logic [15:0] exp_fc = '0;
    bit          exp_seq = 0;

    // Scoreboard queues for read data
    logic [31:0] exp_q [$];
    logic [3:0]  exp_sat_q [$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) exp_cnt[i] = '0;
        for (int i = 0; i < 8; i++) exp_sat[i] = '0;
        cur_ch = 0;
        acq = 0;
        exp_fc = '0;
        exp_seq = 0;
    endtask

    task automatic model_start();
        acq = 1;
        cur_ch = 0;
        if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    endtask

    task automatic model_channel();
        if (acq) begin
            if (cur_ch == 511) begin
                cur_ch = 0;
                exp_seq = 1;
            end else begin
                cur_ch = cur_ch + 1;
            end
        end
    endtask

    task automatic model_event();
        if (acq) begin
            if (exp_cnt[cur_ch] != 32'hFFFF_FFFF) exp_cnt[cur_ch] = exp_cnt[cur_ch] + 32'd1;
            if (exp_sat[cur_ch % 8] != 4'hF) exp_sat[cur_ch % 8] = exp_sat[cur_ch % 8] + 4'd1;
        end
    endtask

    // Driver tasks
    task automatic drive_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        model_start();
    endtask

    task automatic drive_channel();
        channel = 1'b1;
        tick();
        channel = 1'b0;
        tick();
        tick();
        model_channel();
    endtask

    task automatic drive_event();
        lower_threshold = 1'b1;
        repeat (4) tick();
        lower_threshold = 1'b0;
        tick();
        tick();
        model_event();
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    // Read driver: push the expectation, then pop it when rd_valid arrives
    task automatic sb_read(input int addr);
        logic [31:0] e;
        logic [3:0]  es;
        rd_en = 1'b1;
        rd_addr = 9'(addr);
        exp_q.push_back(exp_cnt[addr]);
        exp_sat_q.push_back(exp_sat[addr % 8]);
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || sat_rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_valid addr=%0d: got %b/%b expected 1/1", addr, rd_valid, sat_rd_valid);
        end
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                failures++;
                $display("FAIL rd_data addr=%0d: got %0h expected %0h", addr, rd_data, e);
            end
        end
        if (sat_rd_valid === 1'b1 && exp_sat_q.size() > 0) begin
            es = exp_sat_q.pop_front();
            checks++;
            if (sat_rd_data !== es) begin
                failures++;
                $display("FAIL sat_rd_data addr=%0d: got %0h expected %0h", addr % 8, sat_rd_data, es);
            end
        end
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 512) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected 512", name, cnt);
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        model_reset();
        repeat (3) tick();
        outs = {busy, rd_valid, rd_data, current_channel, frame_count, sequence_error, fsm_state};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", outs);
        end
        areset_n = 1'b1;
        tick();
        count_busy("reset");
        checks++;
        if (fsm_state !== S_IDLE || sat_fsm_state !== S_IDLE || sat_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got state %0d/%0d sat_busy %b expected 1/1 0", fsm_state, sat_fsm_state, sat_busy);
        end
        checks++;
        if (current_channel !== 9'd0 || frame_count !== 16'd0 || sequence_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: got ch %0d fc %0d se %b expected 0 0 0", current_channel, frame_count, sequence_error);
        end
        for (int a = 0; a < 512; a++) sb_read(a);
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid_low: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_idle_ignored();
        drive_event();
        drive_channel();
        settle();
        checks++;
        if (current_channel !== 9'd0 || fsm_state !== S_IDLE) begin
            failures++;
            $display("FAIL idle_ignore: got ch %0d state %0d expected 0 %0d", current_channel, fsm_state, S_IDLE);
        end
        sb_read(0);
        sb_read(1);
        drive_start();
        checks++;
        if (frame_count !== exp_fc || fsm_state !== S_ACQUIRE || current_channel !== 9'd0) begin
            failures++;
            $display("FAIL first_start: got fc %0d state %0d ch %0d expected %0d %0d 0", frame_count, fsm_state, current_channel, exp_fc, S_ACQUIRE);
        end
    endtask

    task automatic test_clean_event();
        repeat (3) drive_channel();
        checks++;
        if (current_channel !== 9'(cur_ch)) begin
            failures++;
            $display("FAIL clean_channel: got %0d expected %0d", current_channel, cur_ch);
        end
        drive_event();
        settle();
        for (int a = 0; a < 8; a++) sb_read(a);
        sb_read(511);
        repeat (9) drive_event();
        settle();
        sb_read(3);
    endtask

    task automatic test_reject();
        // upper high for two cycles in the middle of the lower pulse
        lower_threshold = 1'b1;
        tick(); tick();
        upper_threshold = 1'b1;
        tick(); tick();
        upper_threshold = 1'b0;
        tick(); tick();
        lower_threshold = 1'b0;
        settle();
        sb_read(3);
        // upper rises on exactly the cycle lower falls
        lower_threshold = 1'b1;
        repeat (4) tick();
        lower_threshold = 1'b0;
        upper_threshold = 1'b1;
        tick(); tick();
        upper_threshold = 1'b0;
        settle();
        sb_read(3);
        // a following clean pulse counts again
        drive_event();
        settle();
        sb_read(3);
    endtask

    task automatic test_tag_before_advance();
        lower_threshold = 1'b1;
        repeat (4) tick();
        lower_threshold = 1'b0;
        channel = 1'b1;
        tick();
        channel = 1'b0;
        tick(); tick();
        model_event();
        model_channel();
        settle();
        checks++;
        if (current_channel !== 9'(cur_ch)) begin
            failures++;
            $display("FAIL tag_channel: got %0d expected %0d", current_channel, cur_ch);
        end
        sb_read(3);
        sb_read(4);
    endtask

    task automatic test_back_to_back();
        drive_channel();
        for (int i = 0; i < 100; i++) begin
            lower_threshold = 1'b1;
            tick();
            lower_threshold = 1'b0;
            tick();
            model_event();
        end
        settle();
        sb_read(4);
        sb_read(5);
        sb_read(6);
    endtask

    task automatic test_sequence();
        start = 1'b1;
        channel = 1'b1;
        tick();
        start = 1'b0;
        channel = 1'b0;
        tick(); tick();
        model_start();
        checks++;
        if (current_channel !== 9'd0 || frame_count !== exp_fc) begin
            failures++;
            $display("FAIL start_wins: got ch %0d fc %0d expected 0 %0d", current_channel, frame_count, exp_fc);
        end
        repeat (513) drive_channel();
        checks++;
        if (current_channel !== 9'(cur_ch) || sequence_error !== exp_seq) begin
            failures++;
            $display("FAIL wrap: got ch %0d se %b expected %0d %b", current_channel, sequence_error, cur_ch, exp_seq);
        end
        checks++;
        if (sat_current_channel !== 3'(cur_ch % 8) || sat_sequence_error !== 1'b1 || sat_frame_count !== exp_fc) begin
            failures++;
            $display("FAIL sat_wrap: got ch %0d se %b fc %0d expected %0d 1 %0d", sat_current_channel, sat_sequence_error, sat_frame_count, cur_ch % 8, exp_fc);
        end
    endtask

    task automatic test_clear_in_flight();
        lower_threshold = 1'b1;
        repeat (4) tick();
        lower_threshold = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        count_busy("clear");
        checks++;
        if (fsm_state !== S_IDLE || sequence_error !== 1'b0 || frame_count !== 16'd0 || current_channel !== 9'd0) begin
            failures++;
            $display("FAIL clear_status: got state %0d se %b fc %0d ch %0d expected %0d 0 0 0", fsm_state, sequence_error, frame_count, current_channel, S_IDLE);
        end
        for (int a = 0; a < 512; a++) sb_read(a);
    endtask

    task automatic test_saturation();
        drive_start();
        repeat (3) drive_channel();
        repeat (20) drive_event();
        settle();
        sb_read(3);
        sb_read(2);
        checks++;
        if (frame_count !== exp_fc) begin
            failures++;
            $display("FAIL sat_frame: got %0d expected %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [63:0] outs;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        repeat (100) tick();
        rd_en = 1'b1;
        rd_addr = 9'd0;
        tick();
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_sweep_pre: got busy %b rd_valid %b expected 1 1", busy, rd_valid);
        end
        areset_n = 1'b0;
        #1;
        outs = {busy, rd_valid, rd_data, current_channel, frame_count, sequence_error, fsm_state};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL mid_sweep_reset: got %0h expected 0", outs);
        end
        tick(); tick();
        areset_n = 1'b1;
        tick();
        count_busy("rereset");
        sb_read(3);
        sb_read(5);
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_clean_event();
        test_reject();
        test_tag_before_advance();
        test_back_to_back();
        test_sequence();
        test_clear_in_flight();
        test_saturation();
        test_reset_mid_sweep();
        checks++;
        if (exp_q.size() != 0 || exp_sat_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp_sat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
